// File: rtl/nibble_serial_adder.sv
// Nibble-serial two's-complement adder/subtractor.
// One 4-bit slice is processed per clock, LSB nibble first. The result and
// its flags are published in one step when the last slice completes, so
// partial nibbles never appear on the outputs.
module nibble_serial_adder #(
    parameter int NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   sub,
    input  logic [4*NIBBLES-1:0]   a,
    input  logic [4*NIBBLES-1:0]   b,
    output logic                   busy,
    output logic                   done,
    output logic [4*NIBBLES-1:0]   sum,
    output logic                   carryout,
    output logic                   overflow
);

    localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                    state;
    logic [NIBBLES-1:0][3:0]   a_r;     // latched operand A
    logic [NIBBLES-1:0][3:0]   b_r;     // latched operand B, pre-inverted for subtract
    logic [NIBBLES-1:0][3:0]   work;    // nibbles completed so far
    logic                      carry;
    logic [IW-1:0]             idx;

    logic [4:0]                sl;      // {carry out, sum nibble} of current slice
    logic [3:0]                low3;    // bits [2:0] plus carry, for carry into nibble MSB
    logic [NIBBLES-1:0][3:0]   work_nxt;

    // Current slice: add the selected nibbles plus the running carry.
    // low3[3] is the carry into the nibble's top bit, which on the last
    // slice is the carry into bit W-1 used for signed overflow.
    always_comb begin
        sl       = {1'b0, a_r[idx]} + {1'b0, b_r[idx]} + {4'b0, carry};
        low3     = {1'b0, a_r[idx][2:0]} + {1'b0, b_r[idx][2:0]} + {3'b0, carry};
        work_nxt = work;
        work_nxt[idx] = sl[3:0];
    end

    // Control FSM and datapath registers; all outputs are registered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            a_r      <= '0;
            b_r      <= '0;
            work     <= '0;
            carry    <= 1'b0;
            idx      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            sum      <= '0;
            carryout <= 1'b0;
            overflow <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        // Subtract as a + ~b + 1: invert B and seed carry with sub.
                        a_r   <= a;
                        b_r   <= sub ? ~b : b;
                        carry <= sub;
                        idx   <= '0;
                        work  <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end else begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                RUN: begin
                    work  <= work_nxt;
                    carry <= sl[4];
                    if (idx == LAST) begin
                        sum      <= work_nxt;
                        carryout <= sl[4];
                        overflow <= low3[3] ^ sl[4];
                        done     <= 1'b1;
                        busy     <= 1'b0;
                        state    <= DONE;
                    end else begin
                        // Index only advances inside the operation, never wraps.
                        idx <= idx + IW'(1);
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Scoreboard bench for nibble_serial_adder: the driver pushes expected
// results on issue, an independent monitor pops and compares on done.
module tb_nibble_serial_adder;

    localparam int NIBBLES = 4;
    localparam int W = 4 * NIBBLES;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic         sub = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy, done, carryout, overflow;
    logic [W-1:0] sum;

    nibble_serial_adder #(.NIBBLES(NIBBLES)) dut (
        .clk(clk), .reset(reset), .start(start), .sub(sub), .a(a), .b(b),
        .busy(busy), .done(done), .sum(sum), .carryout(carryout),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] sum;
        logic         co;
        logic         ov;
        int           acc;
    } exp_t;

    exp_t         sb[$];
    exp_t         hold;
    int           cyc = 0;
    int           n_chk = 0;
    int           n_err = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference: plain integer arithmetic on unsigned and signed views.
    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
        exp_t   e;
        longint ux, uy, sx, sy, r, sr;
        longint m;
        m  = longint'(1) << W;
        ux = longint'(x);
        uy = longint'(y);
        sx = x[W-1] ? ux - m : ux;
        sy = y[W-1] ? uy - m : uy;
        if (!s) begin
            r    = ux + uy;
            e.co = (r >= m);
            sr   = sx + sy;
        end else begin
            r    = ux - uy + m;
            e.co = (ux >= uy);
            sr   = sx - sy;
        end
        e.sum = W'(r % m);
        e.ov  = (sr > (m / 2) - 1) || (sr < -(m / 2));
        e.acc = 0;
        return e;
    endfunction

    // Monitor: compare on done, otherwise outputs must hold last result.
    always @(negedge clk) begin
        exp_t e;
        if (done === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 32'(1), 32'(0));
            end else begin
                e = sb.pop_front();
                chk("sum", 32'(sum), 32'(e.sum));
                chk("carryout", 32'(carryout), 32'(e.co));
                chk("overflow", 32'(overflow), 32'(e.ov));
                chk("done_latency", 32'(cyc - e.acc), 32'(NIBBLES));
                hold = e;
            end
        end else begin
            chk("hold_result", 32'({sum, carryout, overflow}),
                32'({hold.sum, hold.co, hold.ov}));
        end
    end

    // Issue one operation; called at a negedge, returns just after the acceptance edge.
    task automatic start_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic s,
                            input bit use_exp, input logic [W-1:0] es,
                            input logic eco, input logic eov);
        exp_t e;
        e = model(x, y, s);
        if (use_exp) begin
            e.sum = es;
            e.co  = eco;
            e.ov  = eov;
        end
        e.acc = cyc + 1;
        start = 1'b1;
        a = x;
        b = y;
        sub = s;
        sb.push_back(e);
        @(posedge clk);
    endtask

    // Wait (bounded) for done; returns at the negedge where done is seen.
    task automatic wait_done(input bit scramble, output int busy_cnt);
        bit found;
        busy_cnt = 0;
        found = 0;
        for (int i = 0; i < 3 * NIBBLES + 4 && !found; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                found = 1;
                chk("busy_in_done", 32'(busy), 32'(0));
            end else begin
                if (busy === 1'b1) busy_cnt++;
                a = W'($urandom);
                b = W'($urandom);
                sub = 1'($urandom);
                start = scramble;
            end
        end
        if (!found) chk("done_timeout", 32'(0), 32'(1));
    endtask

    // Reset for one edge, optionally colliding with a start; called at a negedge.
    task automatic do_reset(input bit with_start);
        reset = 1'b1;
        start = with_start;
        a = W'($urandom);
        b = W'($urandom);
        @(posedge clk);
        #1;
        sb.delete();
        hold = '{sum: '0, co: 1'b0, ov: 1'b0, acc: 0};
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_done", 32'(done), 32'(0));
        chk("rst_sum", 32'(sum), 32'(0));
        chk("rst_flags", 32'({carryout, overflow}), 32'(0));
    endtask

    task automatic idle(input int n);
        start = 1'b0;
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    initial begin
        int bc;
        int mode;
        hold = '{sum: '0, co: 1'b0, ov: 1'b0, acc: 0};
        @(negedge clk);
        do_reset(1'b0);
        idle(2);

        // Basic add with busy window length.
        start_op(16'h0003, 16'h0005, 1'b0, 1, 16'h0008, 1'b0, 1'b0);
        wait_done(0, bc);
        chk("busy_cycles", 32'(bc), 32'(NIBBLES));
        idle(2);

        // Carry ripple through every nibble.
        start_op(16'h7FFF, 16'h0001, 1'b0, 1, 16'h8000, 1'b0, 1'b1);
        wait_done(0, bc);
        start_op(16'hFFFF, 16'hFFFF, 1'b0, 1, 16'hFFFE, 1'b1, 1'b0);
        wait_done(0, bc);
        idle(1);

        // Subtraction, with and without borrow / overflow.
        start_op(16'h0005, 16'h0007, 1'b1, 1, 16'hFFFE, 1'b0, 1'b0);
        wait_done(0, bc);
        start_op(16'h8000, 16'h0001, 1'b1, 1, 16'h7FFF, 1'b1, 1'b1);
        wait_done(0, bc);
        idle(1);

        // start held and operands churned during RUN, then back-to-back op.
        start_op(16'h1357, 16'h2468, 1'b0, 1, 16'h37BF, 1'b0, 1'b0);
        wait_done(1, bc);
        start_op(16'h4000, 16'h4000, 1'b0, 1, 16'h8000, 1'b0, 1'b1);
        wait_done(1, bc);
        idle(2);

        // Reset collides with start: start is discarded.
        do_reset(1'b1);
        @(negedge clk);
        chk("rst_start_busy", 32'(busy), 32'(0));
        idle(1);

        // Abort in the second RUN cycle, then a clean operation.
        start_op(16'hAAAA, 16'h5555, 1'b0, 0, '0, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        do_reset(1'b0);
        idle(NIBBLES + 2);
        start_op(16'h1234, 16'h1111, 1'b0, 1, 16'h2345, 1'b0, 1'b0);
        wait_done(0, bc);
        idle(1);

        // Random operations, mixing gaps, back-to-back issue and input churn.
        for (int n = 0; n < 1200; n++) begin
            start_op(W'($urandom), W'($urandom), 1'($urandom), 0, '0, 1'b0, 1'b0);
            wait_done(1'($urandom_range(0, 3) == 0), bc);
            mode = $urandom_range(0, 2);
            if (mode != 0) idle($urandom_range(1, 3));
        end

        idle(NIBBLES + 3);
        chk("sb_empty", 32'(sb.size()), 32'(0));
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
